filter_sched: RTL

Round-robin scheduler that shares one sparsity `filter` instance among `NREQ` requesters. It grants one job at a time, latches that job's mask triple and drives the filter's load/compute/unload handshake. It returns the result handshake and the job's compute latency to the winning requester. It sits between the tile buffers (requesters) and the filter; data vectors `i_*`/`w_*` are muxed externally using `sel`.

---
 rtl/filter_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/filter_sched.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/filter_pkg.sv
// Shared types and constants for the filter scheduler and its sub-blocks.
package filter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StBusy,
        StDrain
    } sched_state_e;

    localparam logic [1:0] F_READY = 2'b00;
    localparam logic [1:0] F_COMP  = 2'b01;
    localparam logic [1:0] F_DONE  = 2'b10;

    localparam int unsigned DefaultLength = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr_ptr, wrapping at NREQ.
module rr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned p_req = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [p_req-1:0] rr_ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [p_req-1:0] idx,
    output logic             valid
);

    always_comb begin
        int unsigned k;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        k     = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            k = (32'(rr_ptr) + i) % NREQ;
            if (!valid && req[k]) begin
                valid  = 1'b1;
                gnt[k] = 1'b1;
                idx    = k[p_req-1:0];
            end
        end
    end

endmodule

// File: rtl/filter_sched.sv
// Shares one sparsity filter among NREQ requesters: round-robin grant, mask latch,
// filter load/compute/unload handshake and per-job latency reporting.
module filter_sched
    import filter_pkg::*;
#(
    parameter int unsigned length = DefaultLength,
    parameter int unsigned NREQ   = 4,
    parameter int unsigned p_req  = $clog2(NREQ),
    parameter int unsigned CW     = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ-1:0][length-1:0]  o_mask_in,
    input  logic [NREQ-1:0][length-1:0]  xi_mask_in,
    input  logic [NREQ-1:0][length-1:0]  xw_mask_in,
    output logic [NREQ-1:0]              gnt,
    output logic [p_req-1:0]             sel,
    output logic                         f_input_ready,
    output logic [length-1:0]            f_o_mask,
    output logic [length-1:0]            f_xor_i_mask,
    output logic [length-1:0]            f_xor_w_mask,
    input  logic [1:0]                   f_state,
    output logic                         f_output_taken,
    output logic                         res_valid,
    output logic [p_req-1:0]             res_id,
    input  logic                         res_ready,
    output logic [CW-1:0]                res_cycles,
    output logic                         busy
);

    sched_state_e     state_q, state_d;
    logic [p_req-1:0] rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [p_req-1:0] sel_q, sel_d;
    logic [p_req-1:0] res_id_q, res_id_d;
    logic             ir_q, ir_d;
    logic             res_valid_q, busy_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [length-1:0] om_q, om_d, xi_q, xi_d, xw_q, xw_d;

    logic [NREQ-1:0]  arb_gnt;
    logic [p_req-1:0] arb_idx;
    logic             arb_valid;

    rr_arbiter #(
        .NREQ  (NREQ),
        .p_req (p_req)
    ) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .gnt    (arb_gnt),
        .idx    (arb_idx),
        .valid  (arb_valid)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = '0;
        sel_d    = sel_q;
        res_id_d = res_id_q;
        ir_d     = ir_q;
        cnt_d    = cnt_q;
        om_d     = om_q;
        xi_d     = xi_q;
        xw_d     = xw_q;
        unique case (state_q)
            StIdle: begin
                if (arb_valid && f_state == F_READY) begin
                    gnt_d    = arb_gnt;
                    sel_d    = arb_idx;
                    om_d     = o_mask_in[arb_idx];
                    xi_d     = xi_mask_in[arb_idx];
                    xw_d     = xw_mask_in[arb_idx];
                    rr_ptr_d = (arb_idx == p_req'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
                    ir_d     = 1'b1;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                // input_taken from the filter is sticky, so the 01 state is the handshake.
                if (f_state == F_COMP) begin
                    ir_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + 1'b1;
                if (f_state == F_DONE) begin
                    res_id_d = sel_q;
                    state_d  = StDrain;
                end
            end
            StDrain: begin
                if (res_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Also flushes a filter left in DONE when the scheduler is idle.
    always_comb begin
        f_output_taken = 1'b0;
        if (state_q == StDrain) f_output_taken = res_ready;
        else if (state_q == StIdle && f_state == F_DONE) f_output_taken = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            sel_q       <= '0;
            res_id_q    <= '0;
            ir_q        <= 1'b0;
            cnt_q       <= '0;
            om_q        <= '0;
            xi_q        <= '0;
            xw_q        <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            res_id_q    <= res_id_d;
            ir_q        <= ir_d;
            cnt_q       <= cnt_d;
            om_q        <= om_d;
            xi_q        <= xi_d;
            xw_q        <= xw_d;
            res_valid_q <= (state_d == StDrain);
            busy_q      <= (state_d != StIdle);
        end
    end

    assign gnt           = gnt_q;
    assign sel           = sel_q;
    assign f_input_ready = ir_q;
    assign f_o_mask      = om_q;
    assign f_xor_i_mask  = xi_q;
    assign f_xor_w_mask  = xw_q;
    assign res_valid     = res_valid_q;
    assign res_id        = res_id_q;
    assign res_cycles    = cnt_q;
    assign busy          = busy_q;

endmodule
